error_calc_multi: RTL and testbench
===================================

ERROR_CALC_MULTI -- requirements
Module: error_calc_multi

Interface
REQ-001 Parameter WIDTH, default 16: sample and error width in bits.
REQ-002 Parameter CHANNELS, default 4: number of independent error channels.
REQ-003 Parameter IN_SIGNED, default 0: 0 = inputs unsigned, 1 = inputs two's complement.
REQ-004 Parameter AVG_LOG2, default 2: moving-average depth is 2^AVG_LOG2 samples; 0 = no averaging.
REQ-005 Parameter DEADBAND, default 0: non-negative magnitude at or below which the error is forced to 0.
REQ-006 clk  input  1  sole clock; all logic on the rising edge.
REQ-007 reset  input  1  synchronous, active-high reset.
REQ-008 sample_valid  input  1  setpoint/feedback buses valid this cycle.
REQ-009 setpoint  input  CHANNELS*WIDTH  channel k occupies bits [k*WIDTH +: WIDTH].
REQ-010 feedback  input  CHANNELS*WIDTH  packed the same way as setpoint.
REQ-011 flush  input  1  clears averaging history for all channels.
REQ-012 clear_flags  input  1  clears sticky saturation flags.
REQ-013 error  output  CHANNELS*WIDTH  signed filtered error per channel, same packing.
REQ-014 error_valid  output  1  one-cycle strobe marking a new error word.
REQ-015 avg_primed  output  1  high once the averaging window holds 2^AVG_LOG2 real samples.
REQ-016 sat_flag  output  CHANNELS  sticky per-channel saturation indicator.

Function
REQ-017 Stage 1, on sample_valid: per channel, diff = setpoint - feedback, computed in WIDTH+1 bits with IN_SIGNED extension, clamped to [-2^(WIDTH-1), 2^(WIDTH-1)-1], and registered.
REQ-018 A clamp in any channel sets that channel's sat_flag bit in the stage-1 cycle.
REQ-019 Stage 2: per channel, a circular buffer of 2^AVG_LOG2 words plus a running sum of WIDTH+AVG_LOG2 bits; the sum is updated as sum + new - oldest, and the new sample overwrites the oldest.
REQ-020 Average = running sum arithmetically shifted right by AVG_LOG2 (floor toward minus infinity).
REQ-021 History starts as zeros, so averages before priming include zero entries.
REQ-022 With AVG_LOG2 = 0, the buffer and sum are absent and the average equals the stage-1 diff.
REQ-023 Deadband: if |average| <= DEADBAND, the output is 0; otherwise the output is the average unchanged.
REQ-024 Latency: sample_valid at edge N produces error and error_valid = 1 at edge N+2, with all channels aligned.
REQ-025 error holds its value between strobes; error_valid is high only for the one cycle after each stage-2 update.
REQ-026 Back-to-back sample_valid every cycle is accepted at full rate with no stalls.
REQ-027 A fill counter saturates at 2^AVG_LOG2 and counts samples entering stage 2; avg_primed = 1 when the counter is full.
REQ-028 With AVG_LOG2 = 0, avg_primed rises with the first error_valid.
REQ-029 flush zeroes buffers, sums, the fill counter and the stage-1 valid, so an in-flight sample is discarded.
REQ-030 flush has priority over a coincident sample_valid, which is dropped.
REQ-031 flush leaves error and sat_flag unchanged.
REQ-032 clear_flags zeroes sat_flag; a coincident new saturation wins and leaves its bit set.
REQ-033 Buffer pointers wrap modulo 2^AVG_LOG2 with no gap or repeat.

Reset
REQ-034 When reset = 1 at an edge, all of the following are zeroed: error, error_valid, avg_primed, sat_flag, the stage-1 register and valid, buffers, sums, the fill counter and pointers.
REQ-035 Reset has priority over flush, clear_flags and sample_valid; a sample in flight at reset never produces error_valid.
REQ-036 The first sample accepted after reset deasserts is treated as history entry 0.

Verification
REQ-037 WIDTH=16, CHANNELS=2, IN_SIGNED=0, AVG_LOG2=0, DEADBAND=0; ch0 = 1000/400, ch1 = 400/1000 -> two cycles later error ch0 = 600, ch1 = -600, error_valid pulses once.
REQ-038 Same config; ch0 = 65535/0 -> error ch0 = 32767, sat_flag[0] = 1 until clear_flags.
REQ-039 Same config; ch1 = 0/65535 -> error ch1 = -32768, sat_flag[1] = 1.
REQ-040 Same config; clear_flags asserted in the same cycle as a new clamp -> the bit stays 1.
REQ-041 AVG_LOG2=2; constant diff 8 each cycle -> error sequence 2, 4, 6, 8, 8; avg_primed rises with the 4th strobe.
REQ-042 Then diff -3 for 4 cycles -> sequence 5, 2, -1, -3, exercising pointer wrap and floor.
REQ-043 DEADBAND=2, AVG_LOG2=0; diffs 2, -2, 3 -> outputs 0, 0, 3.
REQ-044 sample_valid every cycle with flush at edge N -> the sample accepted at N is dropped, no error_valid at N+2, avg_primed = 0, and the next average restarts from zero history.
REQ-045 reset pulsed one cycle after sample_valid -> no error_valid; all outputs 0 the cycle after reset.

Source files
------------

// File: rtl/error_calc_multi.sv
// ---------------------------------------------------------------------------
// error_calc_multi
//   Multi-channel setpoint/feedback error calculator. Each channel computes
//   a clamped difference, passes it through a power-of-two moving average
//   and a deadband, and presents a signed error word. All channels share
//   one valid pipeline, so their outputs are always aligned.
//
//   Ports
//     clk          : sole clock, rising edge
//     reset        : synchronous, active-high reset
//     sample_valid : setpoint/feedback valid this cycle
//     setpoint     : CHANNELS x WIDTH, channel k at [k*WIDTH +: WIDTH]
//     feedback     : packed like setpoint
//     flush        : clears averaging history and any in-flight sample
//     clear_flags  : clears the sticky saturation flags
//     error        : CHANNELS x WIDTH signed filtered error
//     error_valid  : one-cycle strobe for a new error word
//     avg_primed   : averaging window holds 2^AVG_LOG2 real samples
//     sat_flag     : sticky per-channel clamp indicator
// ---------------------------------------------------------------------------

// Per-channel datapath: stage-1 diff/clamp register, averaging history and
// the output register with deadband.
module error_calc_lane #(
   parameter int WIDTH     = 16,
   parameter int IN_SIGNED = 0,
   parameter int AVG_LOG2  = 2,
   parameter int DEADBAND  = 0,
   parameter int PTR_W     = 2
) (
   input  logic             clk_i,
   input  logic             reset_i,
   input  logic             flush_i,
   input  logic             s1_en_i,
   input  logic             s2_en_i,
   input  logic [PTR_W-1:0] ptr_i,
   input  logic [WIDTH-1:0] setpoint_i,
   input  logic [WIDTH-1:0] feedback_i,
   output logic             sat_o,
   output logic [WIDTH-1:0] error_o
);
   localparam logic [WIDTH:0] DB = (WIDTH+1)'(DEADBAND);

   logic signed [WIDTH:0]   sp_x, fb_x, diff_full, avg_x;
   logic signed [WIDTH-1:0] diff_clamp, s1_q, avg, error_q, error_d;
   logic        [WIDTH:0]   mag;
   logic                    sat;

   // One extra bit holds any difference of two WIDTH-bit values; overflow
   // into that bit is detected by the top two bits disagreeing.
   always_comb begin
      sp_x       = (IN_SIGNED != 0) ? {setpoint_i[WIDTH-1], setpoint_i} : {1'b0, setpoint_i};
      fb_x       = (IN_SIGNED != 0) ? {feedback_i[WIDTH-1], feedback_i} : {1'b0, feedback_i};
      diff_full  = sp_x - fb_x;
      sat        = diff_full[WIDTH] ^ diff_full[WIDTH-1];
      diff_clamp = diff_full[WIDTH-1:0];
      if (sat)
         diff_clamp = diff_full[WIDTH] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
   end

   assign sat_o = sat;

   always_ff @(posedge clk_i) begin
      if (reset_i)      s1_q <= '0;
      else if (s1_en_i) s1_q <= diff_clamp;
   end

   if (AVG_LOG2 > 0) begin : g_avg
      localparam int DEPTH = 1 << AVG_LOG2;
      localparam int SUM_W = WIDTH + AVG_LOG2;

      logic signed [WIDTH-1:0] hist_q [DEPTH];
      logic signed [SUM_W-1:0] sum_q, sum_d;

      // Running sum drops the entry about to be overwritten. Taking the top
      // WIDTH bits is an arithmetic shift, i.e. floor toward minus infinity.
      always_comb begin
         sum_d = sum_q + {{AVG_LOG2{s1_q[WIDTH-1]}}, s1_q}
                       - {{AVG_LOG2{hist_q[ptr_i][WIDTH-1]}}, hist_q[ptr_i]};
         avg   = sum_d[SUM_W-1:AVG_LOG2];
      end

      always_ff @(posedge clk_i) begin
         if (reset_i || flush_i) begin
            sum_q <= '0;
            for (int i = 0; i < DEPTH; i++) hist_q[i] <= '0;
         end else if (s2_en_i) begin
            sum_q         <= sum_d;
            hist_q[ptr_i] <= s1_q;
         end
      end
   end else begin : g_noavg
      logic unused_ok;
      assign unused_ok = ^{ptr_i, flush_i};
      assign avg       = s1_q;
   end

   // Magnitude needs WIDTH+1 bits so the most negative average is handled.
   always_comb begin
      avg_x   = {avg[WIDTH-1], avg};
      mag     = avg_x[WIDTH] ? -avg_x : avg_x;
      error_d = (mag <= DB) ? '0 : avg;
   end

   always_ff @(posedge clk_i) begin
      if (reset_i)      error_q <= '0;
      else if (s2_en_i) error_q <= error_d;
   end

   assign error_o = error_q;
endmodule

module error_calc_multi #(
   parameter int WIDTH     = 16,
   parameter int CHANNELS  = 4,
   parameter int IN_SIGNED = 0,
   parameter int AVG_LOG2  = 2,
   parameter int DEADBAND  = 0
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      sample_valid,
   input  logic [CHANNELS*WIDTH-1:0] setpoint,
   input  logic [CHANNELS*WIDTH-1:0] feedback,
   input  logic                      flush,
   input  logic                      clear_flags,
   output logic [CHANNELS*WIDTH-1:0] error,
   output logic                      error_valid,
   output logic                      avg_primed,
   output logic [CHANNELS-1:0]       sat_flag
);
   localparam int DEPTH  = 1 << AVG_LOG2;
   localparam int PTR_W  = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
   localparam int FILL_W = AVG_LOG2 + 1;

   logic                accept, s2_en;
   logic                s1_vld_q, ev_q;
   logic [PTR_W-1:0]    ptr_q, ptr_d;
   logic [FILL_W-1:0]   fill_q;
   logic [CHANNELS-1:0] sat_now, sat_q, sat_d;

   // flush wins over a coincident sample and kills the one already in stage 1.
   assign accept = sample_valid && !flush;
   assign s2_en  = s1_vld_q && !flush;

   always_comb begin
      ptr_d = (ptr_q == PTR_W'(DEPTH-1)) ? '0 : ptr_q + PTR_W'(1);
      // A new clamp is ORed after the clear so it survives a coincident clear.
      sat_d = (clear_flags ? '0 : sat_q) | (accept ? sat_now : '0);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         s1_vld_q <= 1'b0;
         ev_q     <= 1'b0;
         ptr_q    <= '0;
         fill_q   <= '0;
         sat_q    <= '0;
      end else begin
         s1_vld_q <= accept;
         ev_q     <= s2_en;
         sat_q    <= sat_d;
         if (flush) begin
            ptr_q  <= '0;
            fill_q <= '0;
         end else if (s2_en) begin
            ptr_q <= ptr_d;
            if (fill_q != FILL_W'(DEPTH)) fill_q <= fill_q + FILL_W'(1);
         end
      end
   end

   for (genvar k = 0; k < CHANNELS; k++) begin : g_lane
      error_calc_lane #(
         .WIDTH(WIDTH), .IN_SIGNED(IN_SIGNED), .AVG_LOG2(AVG_LOG2),
         .DEADBAND(DEADBAND), .PTR_W(PTR_W)
      ) u_lane (
         .clk_i      (clk),
         .reset_i    (reset),
         .flush_i    (flush),
         .s1_en_i    (accept),
         .s2_en_i    (s2_en),
         .ptr_i      (ptr_q),
         .setpoint_i (setpoint[k*WIDTH +: WIDTH]),
         .feedback_i (feedback[k*WIDTH +: WIDTH]),
         .sat_o      (sat_now[k]),
         .error_o    (error[k*WIDTH +: WIDTH])
      );
   end

   assign error_valid = ev_q;
   assign avg_primed  = (fill_q == FILL_W'(DEPTH));
   assign sat_flag    = sat_q;
endmodule

// File: tb/tb_error_calc_multi.sv
// ---------------------------------------------------------------------------
// tb_error_calc_multi
//   Directed bench for error_calc_multi. Three instances cover the plain
//   difference path (A), the 4-deep average (B) and the deadband (C).
//   Expected error words are queued when a sample is driven and checked
//   by a per-instance monitor whenever error_valid strobes.
// ---------------------------------------------------------------------------
module tb_error_calc_multi;
   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   logic        svA = 0, flA = 0, clA = 0, svB = 0, flB = 0, clB = 0, svC = 0, flC = 0, clC = 0;
   logic [31:0] spA = 0, fbA = 0, spB = 0, fbB = 0, spC = 0, fbC = 0;
   logic [31:0] erA, erB, erC;
   logic        evA, evB, evC, prA, prB, prC;
   logic [1:0]  stA, stB, stC;

   logic [31:0] qA[$], qB[$], qC[$];
   int errors = 0;
   int checks = 0;

   int dB0 [9] = '{8, 8, 8, 8, 8, -3, -3, -3, -3};
   int eB0 [9] = '{2, 4, 6, 8, 8, 5, 2, -1, -3};
   int eB1 [9] = '{-2, -4, -6, -8, -8, -6, -3, 0, 3};
   int dC0 [3] = '{2, -2, 3};
   int dC1 [3] = '{-3, 3, -2};
   int eC0 [3] = '{0, 0, 3};
   int eC1 [3] = '{-3, 3, 0};

   error_calc_multi #(.WIDTH(16), .CHANNELS(2), .IN_SIGNED(0), .AVG_LOG2(0), .DEADBAND(0)) dA (
      .clk(clk), .reset(reset), .sample_valid(svA), .setpoint(spA), .feedback(fbA),
      .flush(flA), .clear_flags(clA), .error(erA), .error_valid(evA), .avg_primed(prA), .sat_flag(stA));
   error_calc_multi #(.WIDTH(16), .CHANNELS(2), .IN_SIGNED(0), .AVG_LOG2(2), .DEADBAND(0)) dB (
      .clk(clk), .reset(reset), .sample_valid(svB), .setpoint(spB), .feedback(fbB),
      .flush(flB), .clear_flags(clB), .error(erB), .error_valid(evB), .avg_primed(prB), .sat_flag(stB));
   error_calc_multi #(.WIDTH(16), .CHANNELS(2), .IN_SIGNED(0), .AVG_LOG2(0), .DEADBAND(2)) dC (
      .clk(clk), .reset(reset), .sample_valid(svC), .setpoint(spC), .feedback(fbC),
      .flush(flC), .clear_flags(clC), .error(erC), .error_valid(evC), .avg_primed(prC), .sat_flag(stC));

   function automatic logic [31:0] pk(input int c0, input int c1);
      logic [15:0] a, b;
      a = c0[15:0];
      b = c1[15:0];
      return {b, a};
   endfunction

   function automatic int pos(input int d);
      return (d > 0) ? d : 0;
   endfunction

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Scoreboard monitors: every strobe must have a queued expectation.
   always @(negedge clk) if (evA) begin
      checks++;
      assert (qA.size() != 0) else begin errors++; $error("FAIL A_strobe got=1 exp=0"); end
      if (qA.size() != 0) chk("A_error", erA, qA.pop_front());
   end
   always @(negedge clk) if (evB) begin
      checks++;
      assert (qB.size() != 0) else begin errors++; $error("FAIL B_strobe got=1 exp=0"); end
      if (qB.size() != 0) chk("B_error", erB, qB.pop_front());
   end
   always @(negedge clk) if (evC) begin
      checks++;
      assert (qC.size() != 0) else begin errors++; $error("FAIL C_strobe got=1 exp=0"); end
      if (qC.size() != 0) chk("C_error", erC, qC.pop_front());
   end

   initial begin
      repeat (2) @(negedge clk);
      chk("rst_err",   erA, 0);
      chk("rst_ev",    {31'b0, evA}, 0);
      chk("rst_prim",  {31'b0, prA}, 0);
      chk("rst_sat",   {30'b0, stA}, 0);
      chk("rst_primB", {31'b0, prB}, 0);
      reset = 1'b0;

      // Plain difference, both signs.
      @(negedge clk);
      spA = pk(1000, 400); fbA = pk(400, 1000); svA = 1; qA.push_back(pk(600, -600));
      @(negedge clk); svA = 0;
      repeat (3) @(negedge clk);
      chk("A_hold", erA, pk(600, -600));

      // Positive clamp on ch0.
      spA = pk(65535, 0); fbA = pk(0, 0); svA = 1; qA.push_back(pk(32767, 0));
      @(negedge clk); svA = 0;
      chk("A_sat0", {30'b0, stA}, 32'd1);
      repeat (3) @(negedge clk);
      chk("A_sat0_hold", {30'b0, stA}, 32'd1);

      // Negative clamp on ch1.
      spA = pk(0, 0); fbA = pk(0, 65535); svA = 1; qA.push_back(pk(0, -32768));
      @(negedge clk); svA = 0;
      chk("A_sat1", {30'b0, stA}, 32'd3);
      repeat (3) @(negedge clk);

      clA = 1;
      @(negedge clk); clA = 0;
      chk("A_clear", {30'b0, stA}, 0);

      // Clear coincident with a new clamp keeps the bit.
      spA = pk(65535, 0); fbA = pk(0, 0); svA = 1; clA = 1; qA.push_back(pk(32767, 0));
      @(negedge clk); svA = 0; clA = 0;
      chk("A_clr_vs_sat", {30'b0, stA}, 32'd1);
      repeat (3) @(negedge clk);

      // Moving average, priming, wrap and floor.
      for (int i = 0; i < 11; i++) begin
         @(negedge clk);
         chk($sformatf("B_primed_%0d", i), {31'b0, prB}, {31'b0, (i >= 5)});
         if (i < 9) begin
            spB = pk(pos(dB0[i]), pos(-dB0[i]));
            fbB = pk(pos(-dB0[i]), pos(dB0[i]));
            svB = 1;
            qB.push_back(pk(eB0[i], eB1[i]));
         end else svB = 0;
      end
      repeat (3) @(negedge clk);

      // Flush in a full-rate stream: in-flight and coincident samples drop.
      spB = pk(4, 4); fbB = pk(0, 0); svB = 1;
      @(negedge clk);
      spB = pk(100, 100); flB = 1;
      @(negedge clk);
      chk("B_flush_ev",    {31'b0, evB}, 0);
      chk("B_flush_prim",  {31'b0, prB}, 0);
      chk("B_flush_error", erB, pk(-3, 3));
      flB = 0; spB = pk(12, 0); fbB = pk(0, 12); qB.push_back(pk(3, -3));
      @(negedge clk);
      qB.push_back(pk(6, -6));
      @(negedge clk); svB = 0;
      repeat (3) @(negedge clk);
      chk("B_prim_after", {31'b0, prB}, 0);

      // Deadband.
      for (int i = 0; i < 3; i++) begin
         spC = pk(pos(dC0[i]), pos(dC1[i]));
         fbC = pk(pos(-dC0[i]), pos(-dC1[i]));
         svC = 1;
         qC.push_back(pk(eC0[i], eC1[i]));
         @(negedge clk);
      end
      svC = 0;
      repeat (3) @(negedge clk);

      // Reset one cycle after a sample: it never strobes.
      spA = pk(5, 0); fbA = pk(0, 0); svA = 1;
      @(negedge clk); svA = 0; reset = 1;
      @(negedge clk);
      chk("R_err",  erA, 0);
      chk("R_ev",   {31'b0, evA}, 0);
      chk("R_prim", {31'b0, prA}, 0);
      chk("R_sat",  {30'b0, stA}, 0);
      chk("R_errB", erB, 0);
      reset = 0;
      repeat (4) @(negedge clk);

      chk("A_pending", qA.size(), 0);
      chk("B_pending", qB.size(), 0);
      chk("C_pending", qC.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
